// File: rtl/heap_cmd_sched.sv
`default_nettype none
// ============================================================================
// heap_cmd_sched : buffers push/pop/no-op requests, rejects illegal ones using
// a shadow count, and issues them one at a time to the heap controller.
// Optional macro HEAP_CMD_TIMEOUT_EN enables the WAIT-state watchdog.
// Revision: 1.0
// ============================================================================
module heap_cmd_sched #(
    parameter int DEPTH   = 8,
    parameter int KEY_W   = 32,
    parameter int CAP     = 1024,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [KEY_W-1:0]         req_key,
    output logic                     heap_start,
    output logic [1:0]               heap_instruction,
    output logic [KEY_W-1:0]         heap_key,
    input  logic                     heap_done,
    output logic [10:0]              heap_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic                     err_valid,
    output logic [1:0]               err_code
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [10:0]      CAP_C    = 11'(CAP);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    localparam logic [1:0] ERR_ILL = 2'b00;
    localparam logic [1:0] ERR_OVF = 2'b01;
    localparam logic [1:0] ERR_UNF = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("heap_cmd_sched: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    // ------------------------------------------------------------------ FIFO
    logic [KEY_W+1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             enq, deq, empty;
    logic [1:0]       head_op;
    logic [KEY_W-1:0] head_key;

    assign req_ready = (level_q != LVL_FULL);
    assign enq       = req_valid && req_ready;
    assign empty     = (level_q == '0);
    assign {head_op, head_key} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= {req_op, req_key};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (deq) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (enq && !deq)      level_q <= level_q + LVL_ONE;
            else if (!enq && deq) level_q <= level_q - LVL_ONE;
        end
    end

    // ------------------------------------------------------------------ FSM
    logic [1:0]       state_q, state_d;
    logic             start_q, start_d;
    logic [1:0]       instr_q, instr_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [10:0]      count_q, count_d;
    logic             errv_q, errv_d;
    logic [1:0]       errc_q, errc_d;
    logic             legal, expire;
    logic [1:0]       rej_code;

    // Legality of the FIFO head against the shadow count
    always_comb begin
        legal    = 1'b1;
        rej_code = ERR_ILL;
        case (head_op)
            OP_ILL:  legal = 1'b0;
            OP_PUSH: begin
                legal    = (count_q != CAP_C);
                rej_code = ERR_OVF;
            end
            OP_POP:  begin
                legal    = (count_q != 11'd0);
                rej_code = ERR_UNF;
            end
            default: legal = 1'b1;
        endcase
    end

`ifdef HEAP_CMD_TIMEOUT_EN
    localparam int            WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wdog_q;

    always_ff @(posedge clk) begin
        if (!reset_n || state_q != S_WAIT) wdog_q <= '0;
        else                               wdog_q <= wdog_q + WD_W'(1);
    end

    assign expire = (state_q == S_WAIT) && (wdog_q == WD_LAST);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty && legal) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (heap_done || expire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        deq     = 1'b0;
        start_d = 1'b0;
        instr_d = instr_q;
        key_d   = key_q;
        count_d = count_q;
        errv_d  = 1'b0;
        errc_d  = errc_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    deq = 1'b1;
                    if (legal) begin
                        start_d = 1'b1;
                        instr_d = head_op;
                        key_d   = (head_op == OP_PUSH) ? head_key : '0;
                    end else begin
                        errv_d = 1'b1;
                        errc_d = rej_code;
                    end
                end
            end
            S_WAIT: begin
                // Completion beats a simultaneous watchdog expiry
                if (heap_done) begin
                    if (instr_q == OP_PUSH)     count_d = count_q + 11'd1;
                    else if (instr_q == OP_POP) count_d = count_q - 11'd1;
                end else if (expire) begin
                    errv_d = 1'b1;
                    errc_d = ERR_TMO;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_q <= 1'b0;
            instr_q <= OP_NOP;
            key_q   <= '0;
            count_q <= 11'd0;
            errv_q  <= 1'b0;
            errc_q  <= ERR_ILL;
        end else begin
            start_q <= start_d;
            instr_q <= instr_d;
            key_q   <= key_d;
            count_q <= count_d;
            errv_q  <= errv_d;
            errc_q  <= errc_d;
        end
    end

    assign heap_start       = start_q;
    assign heap_instruction = instr_q;
    assign heap_key         = key_q;
    assign heap_count       = count_q;
    assign fifo_level       = level_q;
    assign err_valid        = errv_q;
    assign err_code         = errc_q;
    assign busy             = (state_q != S_IDLE) || !empty;

endmodule
`default_nettype wire

// File: tb/tb_heap_cmd_sched.sv
`default_nettype none
// ============================================================================
// tb_heap_cmd_sched : randomized + directed bench against a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_heap_cmd_sched;

    localparam int DEPTH      = 8;
    localparam int KEY_W      = 32;
    localparam int TB_CAP     = 4;
    localparam int TB_TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic [1:0]             req_op = 2'b00;
    logic [KEY_W-1:0]       req_key = '0;
    logic                   heap_start;
    logic [1:0]             heap_instruction;
    logic [KEY_W-1:0]       heap_key;
    logic                   heap_done = 1'b0;
    logic [10:0]            heap_count;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   busy;
    logic                   err_valid;
    logic [1:0]             err_code;

    heap_cmd_sched #(
        .DEPTH(DEPTH), .KEY_W(KEY_W), .CAP(TB_CAP), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
        .heap_start(heap_start), .heap_instruction(heap_instruction), .heap_key(heap_key),
        .heap_done(heap_done), .heap_count(heap_count), .fifo_level(fifo_level),
        .busy(busy), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: pending queue + one in-flight command
    logic [KEY_W+1:0] m_q[$];
    int               m_cnt = 0;
    bit               m_infl = 0, m_fresh = 1, m_start = 0, m_err = 0, m_ready = 1;
    logic [1:0]       m_code = 0, m_instr = 0;
    logic [KEY_W-1:0] m_key = 0;
    int               m_edge = 0, m_iss = 0, m_done_at = -1;
    bit               chk_en = 0;

    always @(posedge clk) begin
        logic [KEY_W+1:0] e;
        m_edge++;
        m_start = 0;
        m_err   = 0;
        if (!reset_n) begin
            m_q.delete();
            m_cnt = 0; m_infl = 0; m_fresh = 1; m_instr = 0; m_key = 0;
            m_done_at = -1; chk_en = 1;
        end else begin
            if (!m_infl) begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    if (e[KEY_W+1:KEY_W] == 2'b11) begin
                        m_err = 1; m_code = 2'b00;
                    end else if (e[KEY_W+1:KEY_W] == 2'b01 && m_cnt == TB_CAP) begin
                        m_err = 1; m_code = 2'b01;
                    end else if (e[KEY_W+1:KEY_W] == 2'b10 && m_cnt == 0) begin
                        m_err = 1; m_code = 2'b10;
                    end else begin
                        m_start = 1; m_infl = 1; m_fresh = 0;
                        m_instr = e[KEY_W+1:KEY_W];
                        m_key   = (m_instr == 2'b01) ? e[KEY_W-1:0] : '0;
                        m_iss   = m_edge;
                        m_done_at = m_edge + 4;
                    end
                end
            end else if (m_edge >= m_iss + 2) begin
                if (heap_done) begin
                    if (m_instr == 2'b01) m_cnt++;
                    else if (m_instr == 2'b10) m_cnt--;
                    m_infl = 0;
                end
`ifdef HEAP_CMD_TIMEOUT_EN
                else if (m_edge == m_iss + 1 + TB_TIMEOUT) begin
                    m_err = 1; m_code = 2'b11; m_infl = 0;
                end
`endif
            end
            if (req_valid && m_ready) m_q.push_back({req_op, req_key});
        end
        m_ready = (m_q.size() != DEPTH);
    end

    // ---------------- compare process + logs of what the DUT issued
    logic [KEY_W+1:0] start_log[$];
    logic [1:0]       err_log[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("heap_start", heap_start, m_start);
            chk("err_valid", err_valid, m_err);
            if (m_err) chk("err_code", err_code, m_code);
            chk("heap_count", heap_count, m_cnt);
            chk("fifo_level", fifo_level, m_q.size());
            chk("req_ready", req_ready, m_ready);
            chk("busy", busy, m_infl || m_q.size() != 0);
            if (m_infl || m_fresh) begin
                chk("heap_instruction", heap_instruction, m_instr);
                chk("heap_key", heap_key, m_key);
            end
            if (heap_start === 1'b1) start_log.push_back({heap_instruction, heap_key});
            if (err_valid === 1'b1)  err_log.push_back(err_code);
        end
    end

    // ---------------- heap responder: 0 never, 1 four cycles after start, 2 random
    int done_mode = 0;
    int done_pct  = 50;

    always @(negedge clk) begin
        #1;
        case (done_mode)
            1:       heap_done = m_infl && (m_edge + 1 >= m_done_at);
            2:       heap_done = ($urandom_range(0, 99) < done_pct);
            default: heap_done = 1'b0;
        endcase
    end

    // ---------------- stimulus helpers
    task automatic drive(input logic v, input logic [1:0] op, input logic [KEY_W-1:0] k);
        @(negedge clk); #1;
        req_valid = v; req_op = op; req_key = k;
    endtask

    task automatic send(input logic [1:0] op, input logic [KEY_W-1:0] k);
        int n;
        n = 0;
        drive(1'b1, op, k);
        while (!req_ready && n < 100) begin
            drive(1'b1, op, k);
            n++;
        end
        if (n >= 100) chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        drive(1'b0, 2'b00, '0);
        while ((m_infl || m_q.size() != 0) && n < 300) begin
            drive(1'b0, 2'b00, '0);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 64'd1, 64'd0);
        drive(1'b0, 2'b00, '0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset_n = 1'b0; req_valid = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        start_log.delete();
        err_log.delete();
    endtask

    task automatic check_starts(input string nm, input logic [KEY_W+1:0] exp[$]);
        chk({nm, "_nstart"}, start_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk({nm, "_start"}, (i < start_log.size()) ? start_log[i] : {(KEY_W+2){1'bx}}, exp[i]);
    endtask

    initial begin
        logic [KEY_W+1:0] exp_q[$];
        logic [1:0]       op;
        int               r, sel;

        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_count", heap_count, 11'd0);

        // Three back-to-back pushes, done 4 cycles after each start
        done_mode = 1;
        do_reset();
        send(2'b01, 5); send(2'b01, 9); send(2'b01, 3);
        wait_idle();
        exp_q = {};
        exp_q.push_back({2'b01, 32'd5}); exp_q.push_back({2'b01, 32'd9}); exp_q.push_back({2'b01, 32'd3});
        check_starts("A", exp_q);
        chk("A_count", heap_count, 11'd3);
        chk("A_busy", busy, 1'b0);

        // Pop on empty heap rejected, following push still issued
        do_reset();
        send(2'b10, 0); send(2'b01, 7);
        wait_idle();
        chk("B_nerr", err_log.size(), 1);
        chk("B_err", (err_log.size() > 0) ? err_log[0] : 2'bxx, 2'b10);
        exp_q = {};
        exp_q.push_back({2'b01, 32'd7});
        check_starts("B", exp_q);
        chk("B_count", heap_count, 11'd1);

        // Capacity 4: fifth push overflows
        do_reset();
        for (int i = 0; i < 5; i++) send(2'b01, 32'(11 + i));
        wait_idle();
        chk("C_nerr", err_log.size(), 1);
        chk("C_err", (err_log.size() > 0) ? err_log[0] : 2'bxx, 2'b01);
        chk("C_nstart", start_log.size(), 4);
        chk("C_count", heap_count, 11'd4);

        // done held low: FIFO fills to DEPTH, then drains in order
        done_mode = 0;
        do_reset();
        send(2'b01, 100);
        send(2'b01, 1); send(2'b10, 0); send(2'b01, 2); send(2'b10, 0);
        send(2'b01, 3); send(2'b01, 4); send(2'b01, 5); send(2'b10, 0);
        drive(1'b0, 2'b00, '0);
        chk("D_ready", req_ready, 1'b0);
        chk("D_level", fifo_level, 4'd8);
        done_mode = 1;
        wait_idle();
        exp_q = {};
        exp_q.push_back({2'b01, 32'd100}); exp_q.push_back({2'b01, 32'd1}); exp_q.push_back({2'b10, 32'd0});
        exp_q.push_back({2'b01, 32'd2});   exp_q.push_back({2'b10, 32'd0}); exp_q.push_back({2'b01, 32'd3});
        exp_q.push_back({2'b01, 32'd4});   exp_q.push_back({2'b01, 32'd5}); exp_q.push_back({2'b10, 32'd0});
        check_starts("D", exp_q);
        chk("D_count", heap_count, 11'd3);

        // Illegal op then no-op
        do_reset();
        send(2'b11, 32'hDEAD); send(2'b00, 32'hBEEF);
        wait_idle();
        chk("E_err", (err_log.size() > 0) ? err_log[0] : 2'bxx, 2'b00);
        exp_q = {};
        exp_q.push_back({2'b00, 32'd0});
        check_starts("E", exp_q);
        chk("E_count", heap_count, 11'd0);

`ifdef HEAP_CMD_TIMEOUT_EN
        // Watchdog expiry
        done_mode = 0;
        do_reset();
        send(2'b01, 1);
        repeat (25) drive(1'b0, 2'b00, '0);
        chk("T_err", (err_log.size() > 0) ? err_log[0] : 2'bxx, 2'b11);
        chk("T_count", heap_count, 11'd0);
        chk("T_busy", busy, 1'b0);
`endif

        // Reset in the middle of WAIT
        done_mode = 0;
        do_reset();
        send(2'b01, 42);
        send(2'b01, 43);
        repeat (4) drive(1'b0, 2'b00, '0);
        @(negedge clk); #1 reset_n = 1'b0;
        @(negedge clk); #1;
        chk("R_start", heap_start, 1'b0);
        chk("R_instr", heap_instruction, 2'b00);
        chk("R_key", heap_key, 32'd0);
        chk("R_errv", err_valid, 1'b0);
        chk("R_errc", err_code, 2'b00);
        chk("R_count", heap_count, 11'd0);
        chk("R_level", fifo_level, 4'd0);
        chk("R_busy", busy, 1'b0);
        chk("R_ready", req_ready, 1'b1);
        reset_n = 1'b1;

        // Randomized traffic
        done_mode = 2;
        for (int seg = 0; seg < 12; seg++) begin
            sel = $urandom_range(0, 3);
            done_pct = (sel == 0) ? 0 : (sel == 1) ? 10 : (sel == 2) ? 40 : 90;
            for (int c = 0; c < 250; c++) begin
                r  = $urandom_range(0, 99);
                op = (r < 40) ? 2'b01 : (r < 75) ? 2'b10 : (r < 90) ? 2'b00 : 2'b11;
                @(negedge clk); #1;
                reset_n   = ($urandom_range(0, 399) != 0);
                req_valid = ($urandom_range(0, 1) == 1);
                req_op    = op;
                req_key   = $urandom;
            end
        end
        done_mode = 1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
